counter: RTL and testbench
==========================

Name: counter

Overview:
- Time-of-day counter for the digital alarm clock; holds current time as four BCD digits, 24-hour format (HH:MM).
- Advances one minute per qualified `one_minute` tick from the upstream timing generator.
- Accepts a parallel load of a new time from the keypad/set logic.
- Outputs feed the display driver and alarm comparator.

Parameters:
- MAX_HR_MS, 2, maximum tens-of-hours digit (wrap point 23:59 -> 00:00).
- MAX_HR_LS_AT_MAX, 3, maximum units-of-hours digit when the tens-of-hours digit equals MAX_HR_MS.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- one_minute  input  1  synchronous advance enable; 1 = add one minute this cycle.
- load_new_c  input  1  synchronous load strobe for the new time.
- new_current_time_ms_hr  input  4  BCD tens of hours to load (0-2).
- new_current_time_ls_hr  input  4  BCD units of hours to load (0-9).
- new_current_time_ms_min  input  4  BCD tens of minutes to load (0-5).
- new_current_time_ls_min  input  4  BCD units of minutes to load (0-9).
- current_time_ms_hr  output  4  BCD tens of hours.
- current_time_ls_hr  output  4  BCD units of hours.
- current_time_ms_min  output  4  BCD tens of minutes.
- current_time_ls_min  output  4  BCD units of minutes.

Behaviour:
- Reset:
  - `reset` = 0 asynchronously forces all four outputs to 0 (00:00), independent of `clk`.
  - Outputs stay at 00:00 while `reset` is low.
  - Normal operation resumes at the first rising edge after `reset` returns to 1.
- Outputs are registered, driven directly from the state flops; no combinational paths from inputs to outputs.
- Priority per rising edge: reset > load > advance > hold.
- Load:
  - `load_new_c` = 1 at a rising edge captures the four new_* digits if the value is valid; new time is visible after that edge (1-cycle latency).
  - Valid means: ms_hr <= 2, ls_hr <= 9, ms_min <= 5, ls_min <= 9, and if ms_hr = 2 then ls_hr <= 3.
  - An invalid load value is discarded; the counter holds its current value for that cycle. It neither loads nor advances.
  - Load takes precedence over a simultaneous `one_minute`; that tick is dropped.
- Advance:
  - `one_minute` is a level enable, not edge-detected. Each rising edge with `one_minute` = 1 and `load_new_c` = 0 adds exactly one minute.
  - ls_min 0-8: increment.
  - ls_min 9: ls_min -> 0, carry into ms_min.
  - ms_min carry: 0-4 increment; 5 -> 0 and carry into hours.
  - Hours carry: ls_hr 0-8 increments, except that at ms_hr = 2 and ls_hr = 3 hours wrap to 00.
  - Hours carry: ls_hr 9 -> 0 and ms_hr increments (09 -> 10, 19 -> 20).
  - 23:59 + 1 minute -> 00:00.
- Hold: with neither `load_new_c` nor `one_minute` asserted, all digits are unchanged.
- Digits never take non-BCD or out-of-range values. Reachable states are only 00:00 to 23:59.

Test Plan:
- Assert `reset` = 0 mid-count, asynchronously, between clock edges -> outputs become 0,0,0,0 immediately, before the next edge. Release `reset` -> 00:00 held until a tick.
- Load 0,9,1,6 with `load_new_c` high for one edge -> 09:16 after that edge. Then toggle `one_minute` high every other cycle for 44 ticks -> 10:00.
- Load 1,8,3,2 while `one_minute` = 1 in the same cycle -> exactly 18:32 (tick dropped). The next tick gives 18:33.
- Load 2,3,5,9, then one tick -> 00:00. Also check 19:59 + 1 -> 20:00 and 00:59 + 1 -> 01:00.
- Invalid loads are ignored: from 12:34, load 2,4,0,0 -> stays 12:34; load 1,2,6,0 -> stays 12:34; load 0,0,0,10 -> stays 12:34.
- `one_minute` held continuously high for 1440 cycles from 00:00 -> returns to 00:00, passing through 23:59 on cycle 1439.

Source files
------------

// File: rtl/counter.sv
// counter: 24-hour BCD time-of-day counter (HH:MM) with validated parallel load
//
// Ports:
//   clk                      in   1  system clock, rising edge
//   reset                    in   1  asynchronous active-low reset, forces 00:00
//   one_minute               in   1  level enable, adds one minute per rising edge
//   load_new_c               in   1  load strobe for new_current_time_* (wins over one_minute)
//   new_current_time_ms_hr   in   4  BCD tens of hours to load
//   new_current_time_ls_hr   in   4  BCD units of hours to load
//   new_current_time_ms_min  in   4  BCD tens of minutes to load
//   new_current_time_ls_min  in   4  BCD units of minutes to load
//   current_time_ms_hr       out  4  BCD tens of hours (registered)
//   current_time_ls_hr       out  4  BCD units of hours (registered)
//   current_time_ms_min      out  4  BCD tens of minutes (registered)
//   current_time_ls_min      out  4  BCD units of minutes (registered)
module counter #(
    parameter logic [3:0] MAX_HR_MS        = 4'd2,
    parameter logic [3:0] MAX_HR_LS_AT_MAX = 4'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_minute,
    input  logic       load_new_c,
    input  logic [3:0] new_current_time_ms_hr,
    input  logic [3:0] new_current_time_ls_hr,
    input  logic [3:0] new_current_time_ms_min,
    input  logic [3:0] new_current_time_ls_min,
    output logic [3:0] current_time_ms_hr,
    output logic [3:0] current_time_ls_hr,
    output logic [3:0] current_time_ms_min,
    output logic [3:0] current_time_ls_min
);
    logic [3:0] r_ms_hr, r_ls_hr, r_ms_min, r_ls_min;
    logic [3:0] w_ms_hr, w_ls_hr, w_ms_min, w_ls_min;
    logic       w_load_ok, w_ls_min_wrap, w_ms_min_wrap, w_day_wrap;

    // An invalid load is dropped entirely: the cycle holds, it does not fall back to advancing.
    assign w_load_ok = (new_current_time_ms_hr <= MAX_HR_MS) &&
                       (new_current_time_ls_hr <= 4'd9) &&
                       (new_current_time_ms_min <= 4'd5) &&
                       (new_current_time_ls_min <= 4'd9) &&
                       ((new_current_time_ms_hr != MAX_HR_MS) || (new_current_time_ls_hr <= MAX_HR_LS_AT_MAX));

    assign w_ls_min_wrap = (r_ls_min == 4'd9);
    assign w_ms_min_wrap = w_ls_min_wrap && (r_ms_min == 4'd5);
    assign w_day_wrap    = w_ms_min_wrap && (r_ms_hr == MAX_HR_MS) && (r_ls_hr == MAX_HR_LS_AT_MAX);

    // Time plus one minute, ripple-carry through the four BCD digits.
    always_comb begin
        w_ls_min = w_ls_min_wrap ? 4'd0 : r_ls_min + 4'd1;
        w_ms_min = !w_ls_min_wrap ? r_ms_min : (w_ms_min_wrap ? 4'd0 : r_ms_min + 4'd1);
        w_ls_hr  = !w_ms_min_wrap ? r_ls_hr :
                   (w_day_wrap || r_ls_hr == 4'd9) ? 4'd0 : r_ls_hr + 4'd1;
        w_ms_hr  = !w_ms_min_wrap ? r_ms_hr :
                   w_day_wrap ? 4'd0 : (r_ls_hr == 4'd9) ? r_ms_hr + 4'd1 : r_ms_hr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {r_ms_hr, r_ls_hr, r_ms_min, r_ls_min} <= 16'h0000;
        end else if (load_new_c) begin
            if (w_load_ok)
                {r_ms_hr, r_ls_hr, r_ms_min, r_ls_min} <= {new_current_time_ms_hr, new_current_time_ls_hr,
                                                           new_current_time_ms_min, new_current_time_ls_min};
        end else if (one_minute) begin
            {r_ms_hr, r_ls_hr, r_ms_min, r_ls_min} <= {w_ms_hr, w_ls_hr, w_ms_min, w_ls_min};
        end
    end

    assign current_time_ms_hr  = r_ms_hr;
    assign current_time_ls_hr  = r_ls_hr;
    assign current_time_ms_min = r_ms_min;
    assign current_time_ls_min = r_ls_min;
endmodule

// File: tb/tb_counter.sv
// tb_counter: directed self-checking bench for the BCD time-of-day counter
module tb_counter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       one_minute = 1'b0;
    logic       load_new_c = 1'b0;
    logic [3:0] n_ms_hr = 4'd0, n_ls_hr = 4'd0, n_ms_min = 4'd0, n_ls_min = 4'd0;
    logic [3:0] c_ms_hr, c_ls_hr, c_ms_min, c_ls_min;
    logic [15:0] obs;
    int n_cmp = 0;
    int n_bad = 0;

    counter dut (
        .clk(clk),
        .reset(reset),
        .one_minute(one_minute),
        .load_new_c(load_new_c),
        .new_current_time_ms_hr(n_ms_hr),
        .new_current_time_ls_hr(n_ls_hr),
        .new_current_time_ms_min(n_ms_min),
        .new_current_time_ls_min(n_ls_min),
        .current_time_ms_hr(c_ms_hr),
        .current_time_ls_hr(c_ls_hr),
        .current_time_ms_min(c_ms_min),
        .current_time_ls_min(c_ls_min)
    );

    always #5 clk = ~clk;
    assign obs = {c_ms_hr, c_ls_hr, c_ms_min, c_ls_min};

    // Minutes since midnight -> packed BCD HHMM.
    function automatic logic [15:0] bcd(input int k);
        int h, m;
        h = (k / 60) % 24;
        m = k % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v, input logic tick);
        {n_ms_hr, n_ls_hr, n_ms_min, n_ls_min} = v;
        load_new_c = 1'b1;
        one_minute = tick;
        step();
        load_new_c = 1'b0;
        one_minute = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++;
        if (obs !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_held got %h want 0000", obs);
        end
        #2 reset = 1'b1;
        step();
        step();
        n_cmp++;
        if (obs !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_release_hold got %h want 0000", obs);
        end
    endtask

    task automatic test_load_advance();
        load(16'h0916, 1'b0);
        n_cmp++;
        if (obs !== 16'h0916) begin
            n_bad++;
            $display("FAIL load_0916 got %h want 0916", obs);
        end
        for (int i = 0; i < 44; i++) begin
            one_minute = 1'b1;
            step();
            one_minute = 1'b0;
            step();
            if (i == 42) begin
                n_cmp++;
                if (obs !== 16'h0959) begin
                    n_bad++;
                    $display("FAIL adv_0959 got %h want 0959", obs);
                end
            end
        end
        n_cmp++;
        if (obs !== 16'h1000) begin
            n_bad++;
            $display("FAIL adv_1000 got %h want 1000", obs);
        end
    endtask

    task automatic test_load_priority();
        load(16'h1832, 1'b1);
        n_cmp++;
        if (obs !== 16'h1832) begin
            n_bad++;
            $display("FAIL load_over_tick got %h want 1832", obs);
        end
        one_minute = 1'b1;
        step();
        one_minute = 1'b0;
        n_cmp++;
        if (obs !== 16'h1833) begin
            n_bad++;
            $display("FAIL tick_after_load got %h want 1833", obs);
        end
    endtask

    task automatic test_wraps();
        logic [15:0] from_v[3] = '{16'h2359, 16'h1959, 16'h0059};
        logic [15:0] to_v[3]   = '{16'h0000, 16'h2000, 16'h0100};
        for (int i = 0; i < 3; i++) begin
            load(from_v[i], 1'b0);
            one_minute = 1'b1;
            step();
            one_minute = 1'b0;
            n_cmp++;
            if (obs !== to_v[i]) begin
                n_bad++;
                $display("FAIL wrap_%h got %h want %h", from_v[i], obs, to_v[i]);
            end
        end
    endtask

    task automatic test_invalid_load();
        logic [15:0] bad_v[4] = '{16'h2400, 16'h1260, 16'h000A, 16'h3000};
        load(16'h1234, 1'b0);
        for (int i = 0; i < 4; i++) begin
            load(bad_v[i], 1'b1);
            n_cmp++;
            if (obs !== 16'h1234) begin
                n_bad++;
                $display("FAIL invalid_%h got %h want 1234", bad_v[i], obs);
            end
        end
    endtask

    task automatic test_hold();
        load(16'h0745, 1'b0);
        repeat (5) step();
        n_cmp++;
        if (obs !== 16'h0745) begin
            n_bad++;
            $display("FAIL hold got %h want 0745", obs);
        end
    endtask

    task automatic test_full_day();
        load(16'h0000, 1'b0);
        one_minute = 1'b1;
        for (int k = 1; k <= 1440; k++) begin
            step();
            n_cmp++;
            if (obs !== bcd(k)) begin
                n_bad++;
                $display("FAIL day_cycle_%0d got %h want %h", k, obs, bcd(k));
            end
        end
        one_minute = 1'b0;
    endtask

    task automatic test_async_reset();
        load(16'h1547, 1'b0);
        one_minute = 1'b1;
        step();
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 16'h0000) begin
            n_bad++;
            $display("FAIL async_reset got %h want 0000", obs);
        end
        step();
        step();
        n_cmp++;
        if (obs !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_low_tick got %h want 0000", obs);
        end
        one_minute = 1'b0;
        #2 reset = 1'b1;
        step();
        step();
        n_cmp++;
        if (obs !== 16'h0000) begin
            n_bad++;
            $display("FAIL post_reset_hold got %h want 0000", obs);
        end
        one_minute = 1'b1;
        step();
        one_minute = 1'b0;
        n_cmp++;
        if (obs !== 16'h0001) begin
            n_bad++;
            $display("FAIL post_reset_tick got %h want 0001", obs);
        end
    endtask

    initial begin
        test_reset();
        test_load_advance();
        test_load_priority();
        test_wraps();
        test_invalid_load();
        test_hold();
        test_full_day();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
